i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter DIV, default 4: clock cycles per SCL quarter-period; legal range >= 2.
REQ-002 clock  input  1  system clock; all logic rising-edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 start_req  input  1  one-cycle request to begin a transaction.
REQ-005 rw  input  1  0 = write, 1 = read; sampled with start_req.
REQ-006 addr  input  7  target address; sampled with start_req.
REQ-007 wr_data  input  8  byte to write; sampled with start_req.
REQ-008 SDA_in  input  1  synchronized bus SDA level.
REQ-009 SCL_out  output  1  open-drain SCL drive; 1 = release, 0 = pull low.
REQ-010 SDA_out  output  1  open-drain SDA drive; 1 = release, 0 = pull low.
REQ-011 busy  output  1  high from the cycle after an accepted start_req until done.
REQ-012 done  output  1  one-cycle pulse when the transaction ends.
REQ-013 nack_err  output  1  transaction aborted on NACK; valid with done, held until next accepted start_req.
REQ-014 rd_data  output  8  received byte; updated at read completion.

Function
REQ-015 Timing: a quarter tick every DIV clocks while busy; each bit slot is Q0..Q3; the tick counter clears on start_req acceptance.
REQ-016 Data slot: Q0-Q1 SCL=0, SDA_out set at Q0 entry; Q2-Q3 SCL=1; SDA_in sampled on the Q2->Q3 tick.
REQ-017 START slot: Q0-Q1 SCL=1, SDA=1; Q2-Q3 SCL=1, SDA=0.
REQ-018 STOP slot: Q0 SCL=0, SDA=0; Q1 SCL=1, SDA=0; Q2-Q3 SCL=1, SDA=1.
REQ-019 States: IDLE -> START -> ADDR(8 slots) -> ADDR_ACK -> {WDATA(8) -> WDATA_ACK | RDATA(8) -> RDATA_ACK} -> STOP -> IDLE.
REQ-020 IDLE: SCL_out=1, SDA_out=1, busy=0; start_req accepted only in IDLE; start_req while busy is ignored.
REQ-021 ADDR sends {addr, rw} MSB first; WDATA sends wr_data MSB first.
REQ-022 ADDR_ACK/WDATA_ACK: SDA_out=1; sampled SDA_in=1 sets nack_err and goes straight to STOP.
REQ-023 RDATA: SDA_out=1; sampled bits shift in MSB first; rd_data loads the full byte at the end of the eighth slot.
REQ-024 RDATA_ACK: master drives SDA_out=1 (NACK, single-byte read).
REQ-025 done pulses on the cycle STOP Q3 ends; busy falls the same cycle.
REQ-026 Latency: a write with ACKs takes 20 slots = 80*DIV clocks from acceptance to done.
REQ-027 A read with ACK also takes 20 slots; an address NACK takes 11 slots.

Reset
REQ-028 Reset at any time, including mid-transaction, forces IDLE with SCL_out=1, SDA_out=1, busy=0, done=0, nack_err=0, rd_data=8'h00, and counters cleared.
REQ-029 No STOP is generated on reset; a start_req coincident with reset deassertion is ignored.

Structure
REQ-030 Shared package i2c_pkg holds the state enum, the slot phase enum (Q0-Q3), and constant TARGET_ADDR = 7'h20.
REQ-031 Sub-module i2c_tick_gen (DIV counter, quarter index, bit counter 0-7 with slot_end flag); the FSM and shift registers stay in i2c_master.

Verification
REQ-032 Write: addr=7'h20, rw=0, wr_data=8'hA5, target ACKs both bytes -> bus bits 0x40, 0xA5; done at 80*DIV; nack_err=0.
REQ-033 Read: addr=7'h20, rw=1, target returns 8'h3C -> rd_data=8'h3C; master NACKs; STOP follows; done pulses.
REQ-034 Address NACK: addr=7'h21, SDA_in held 1 -> nack_err=1; STOP directly after ADDR_ACK; done at 44*DIV.
REQ-035 start_req pulsed mid-transaction -> ignored; bus waveform unchanged.
REQ-036 Reset asserted during WDATA bit 3 -> next clock SCL_out=1, SDA_out=1, busy=0; a new write then completes normally.
REQ-037 Protocol checker: SDA changes only while SCL=0 except in START/STOP slots; exactly one START and one STOP per transaction.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
// Imported by the tick generator, the master FSM and the bench.
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_STOP
    } state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } phase_t;

    localparam logic [6:0] TARGET_ADDR = 7'h20;

endpackage

// File: rtl/i2c_master_if.sv
// Request/status and open-drain bus signals of the I2C master.
// master = the controller side, slave = the user/bus side.
interface i2c_master_if;

    logic       start_req;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wr_data;
    logic       SDA_in;
    logic       SCL_out;
    logic       SDA_out;
    logic       busy;
    logic       done;
    logic       nack_err;
    logic [7:0] rd_data;

    modport master (
        input  start_req, rw, addr, wr_data, SDA_in,
        output SCL_out, SDA_out, busy, done, nack_err, rd_data
    );

    modport slave (
        output start_req, rw, addr, wr_data, SDA_in,
        input  SCL_out, SDA_out, busy, done, nack_err, rd_data
    );

endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-period timing: DIV clocks per quarter, four quarters per
// bit slot, and a 0-7 bit counter for the multi-slot byte states.
import i2c_pkg::*;

module i2c_tick_gen #(
    parameter int DIV = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   clear,
    input  logic   run,
    input  logic   count_en,
    output phase_t quarter,
    output logic   tick,
    output logic   slot_end,
    output logic   last_bit
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] div_cnt;
    logic [2:0]    bit_cnt;

    assign tick     = run && (div_cnt == CW'(DIV - 1));
    assign slot_end = tick && (quarter == Q3);
    assign last_bit = (bit_cnt == 3'd7);

    // bit_cnt falls back to 0 in single-slot states so every byte starts at bit 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            quarter <= Q0;
            bit_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
            quarter <= Q0;
            bit_cnt <= '0;
        end else if (run) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                quarter <= phase_t'(quarter + 2'd1);
            if (slot_end)
                bit_cnt <= count_en ? bit_cnt + 3'd1 : 3'd0;
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+rw, one data byte
// (write or read with final NACK), STOP; aborts on NACK.
import i2c_pkg::*;

module i2c_master #(
    parameter int DIV = 4
) (
    input  logic         clock,
    input  logic         reset,
    i2c_master_if.master bus
);

    state_t     state;
    state_t     state_nx;
    phase_t     quarter;
    logic       tick;
    logic       slot_end;
    logic       last_bit;
    logic       run;
    logic       accept;
    logic       sample;
    logic       count_en;
    logic       armed;
    logic       sda_s;
    logic       rw_q;
    logic       done_q;
    logic       nack_q;
    logic       scl;
    logic       sda;
    logic [7:0] tx_sr;
    logic [7:0] wdata_q;
    logic [7:0] rx_sr;
    logic [7:0] rd_q;

    assign run      = (state != S_IDLE);
    assign accept   = (state == S_IDLE) && armed && bus.start_req;
    assign sample   = tick && (quarter == Q2);
    assign count_en = state inside {S_ADDR, S_WDATA, S_RDATA};

    i2c_tick_gen #(.DIV(DIV)) u_tick (
        .clock    (clock),
        .reset    (reset),
        .clear    (accept),
        .run      (run),
        .count_en (count_en),
        .quarter  (quarter),
        .tick     (tick),
        .slot_end (slot_end),
        .last_bit (last_bit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            state_nx = S_START;
        end else if (slot_end) begin
            case (state)
                S_START:     state_nx = S_ADDR;
                S_ADDR:      if (last_bit) state_nx = S_ADDR_ACK;
                S_ADDR_ACK:  state_nx = sda_s ? S_STOP
                                      : (rw_q ? S_RDATA : S_WDATA);
                S_WDATA:     if (last_bit) state_nx = S_WDATA_ACK;
                S_WDATA_ACK: state_nx = S_STOP;
                S_RDATA:     if (last_bit) state_nx = S_RDATA_ACK;
                S_RDATA_ACK: state_nx = S_STOP;
                S_STOP:      state_nx = S_IDLE;
                default:     state_nx = state;
            endcase
        end
    end

    // ACK, read and read-NACK slots keep SDA released
    always_comb begin
        scl = 1'b1;
        sda = 1'b1;
        unique case (state)
            S_IDLE: begin
                scl = 1'b1;
                sda = 1'b1;
            end
            S_START: begin
                scl = 1'b1;
                sda = ~quarter[1];
            end
            S_STOP: begin
                scl = (quarter != Q0);
                sda = quarter[1];
            end
            S_ADDR, S_WDATA: begin
                scl = quarter[1];
                sda = tx_sr[7];
            end
            default: begin
                scl = quarter[1];
                sda = 1'b1;
            end
        endcase
    end

    // armed blocks a request on the first edge after reset release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed   <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
            rd_q    <= 8'h00;
            tx_sr   <= 8'h00;
            wdata_q <= 8'h00;
            rx_sr   <= 8'h00;
            rw_q    <= 1'b0;
            sda_s   <= 1'b1;
        end else begin
            armed  <= 1'b1;
            done_q <= (state == S_STOP) && slot_end;
            if (accept) begin
                tx_sr   <= {bus.addr, bus.rw};
                wdata_q <= bus.wr_data;
                rw_q    <= bus.rw;
                nack_q  <= 1'b0;
            end
            if (sample) begin
                sda_s <= bus.SDA_in;
                if (state == S_RDATA)
                    rx_sr <= {rx_sr[6:0], bus.SDA_in};
            end
            if (slot_end) begin
                if (state == S_ADDR && last_bit)
                    tx_sr <= wdata_q;
                else if (state inside {S_ADDR, S_WDATA})
                    tx_sr <= {tx_sr[6:0], 1'b0};
                if (state == S_RDATA && last_bit)
                    rd_q <= rx_sr;
                if ((state inside {S_ADDR_ACK, S_WDATA_ACK}) && sda_s)
                    nack_q <= 1'b1;
            end
        end
    end

    assign bus.SCL_out  = scl;
    assign bus.SDA_out  = sda;
    assign bus.busy     = run;
    assign bus.done     = done_q;
    assign bus.nack_err = nack_q;
    assign bus.rd_data  = rd_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a bus-level target model
// and a START/STOP/SDA-stability monitor on the wired bus.
import i2c_pkg::*;

module tb_i2c_master;

    localparam int DIV = 4;

    logic clock;
    logic reset;
    logic tgt_sda;
    logic [7:0] tgt_rd;

    int checks;
    int errors;

    i2c_master_if bus ();

    assign bus.SDA_in = bus.SDA_out & tgt_sda;

    i2c_master #(.DIV(DIV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // bus monitor and target, observed mid-cycle
    logic       prev_scl;
    logic       prev_sda;
    int         nbit;
    int         n_start;
    int         n_stop;
    int         n_viol;
    logic [7:0] mon_addr;
    logic [7:0] mon_data;
    logic       mon_ack1;
    logic       mon_ack2;

    initial begin
        prev_scl = 1'b1;
        prev_sda = 1'b1;
        nbit     = 0;
        n_start  = 0;
        n_stop   = 0;
        n_viol   = 0;
        mon_addr = 8'h00;
        mon_data = 8'h00;
        mon_ack1 = 1'b1;
        mon_ack2 = 1'b1;
        tgt_sda  = 1'b1;
    end

    always @(negedge clock) begin
        logic cs;
        logic cd;
        cs = bus.SCL_out;
        cd = bus.SDA_in;
        if (reset) begin
            prev_scl = 1'b1;
            prev_sda = 1'b1;
            nbit     = 0;
            tgt_sda  = 1'b1;
        end else begin
            if (prev_scl && cs && prev_sda && !cd) begin
                n_start++;
                nbit    = 0;
                tgt_sda = 1'b1;
            end
            if (prev_scl && cs && !prev_sda && cd)
                n_stop++;
            if (!prev_scl && cs && (prev_sda != cd))
                n_viol++;
            if (!prev_scl && cs) begin
                if (nbit < 8)
                    mon_addr = {mon_addr[6:0], cd};
                else if (nbit == 8)
                    mon_ack1 = cd;
                else if (nbit < 17)
                    mon_data = {mon_data[6:0], cd};
                else if (nbit == 17)
                    mon_ack2 = cd;
                nbit++;
            end
            if (prev_scl && !cs) begin
                tgt_sda = 1'b1;
                if (mon_addr[7:1] == TARGET_ADDR) begin
                    if (nbit == 8 || (nbit == 17 && !mon_addr[0]))
                        tgt_sda = 1'b0;
                    else if (mon_addr[0] && nbit >= 9 && nbit <= 16)
                        tgt_sda = tgt_rd[16 - nbit];
                end
            end
            prev_scl = cs;
            prev_sda = cd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // issue a request, count clocks from acceptance to done
    task automatic run_txn(input logic r, input logic [6:0] a,
                           input logic [7:0] d, input bit poke,
                           output int cyc, output bit got,
                           output logic busy1);
        @(negedge clock);
        bus.start_req = 1'b1;
        bus.rw        = r;
        bus.addr      = a;
        bus.wr_data   = d;
        @(posedge clock);
        #1 bus.start_req = 1'b0;
        cyc   = 0;
        got   = 1'b0;
        busy1 = 1'b0;
        while (!got && cyc < 400 * DIV) begin
            @(posedge clock);
            cyc++;
            #1;
            if (cyc == 1)
                busy1 = bus.busy;
            if (poke && cyc == 30 * DIV) begin
                bus.start_req = 1'b1;
                bus.rw        = 1'b1;
                bus.addr      = 7'h55;
                bus.wr_data   = 8'h00;
            end
            if (poke && cyc == 30 * DIV + 1)
                bus.start_req = 1'b0;
            if (bus.done)
                got = 1'b1;
        end
    endtask

    initial begin
        int   cyc;
        bit   got;
        logic busy1;
        int   s0;
        int   p0;
        int   v0;

        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        tgt_rd        = 8'h3C;
        bus.start_req = 1'b0;
        bus.rw        = 1'b0;
        bus.addr      = 7'h00;
        bus.wr_data   = 8'h00;

        repeat (3) @(posedge clock);
        #1;
        check("rst_scl", bus.SCL_out, 1);
        check("rst_sda", bus.SDA_out, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_nack", bus.nack_err, 0);
        check("rst_rd", bus.rd_data, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // write with ACKs
        s0 = n_start; p0 = n_stop; v0 = n_viol;
        run_txn(1'b0, 7'h20, 8'hA5, 1'b0, cyc, got, busy1);
        check("wr_done_seen", got, 1);
        check("wr_latency", cyc, 80 * DIV);
        check("wr_busy1", busy1, 1);
        check("wr_busy_end", bus.busy, 0);
        check("wr_nack", bus.nack_err, 0);
        check("wr_addr_byte", mon_addr, 8'h40);
        check("wr_ack1", mon_ack1, 0);
        check("wr_data_byte", mon_data, 8'hA5);
        check("wr_ack2", mon_ack2, 0);
        check("wr_starts", n_start - s0, 1);
        check("wr_stops", n_stop - p0, 1);
        check("wr_sda_viol", n_viol - v0, 0);
        @(posedge clock);
        #1 check("wr_done_pulse", bus.done, 0);

        // read
        s0 = n_start; p0 = n_stop; v0 = n_viol;
        run_txn(1'b1, 7'h20, 8'h00, 1'b0, cyc, got, busy1);
        check("rd_done_seen", got, 1);
        check("rd_latency", cyc, 80 * DIV);
        check("rd_data", bus.rd_data, 8'h3C);
        check("rd_addr_byte", mon_addr, 8'h41);
        check("rd_bus_byte", mon_data, 8'h3C);
        check("rd_master_nack", mon_ack2, 1);
        check("rd_nack_err", bus.nack_err, 0);
        check("rd_starts", n_start - s0, 1);
        check("rd_stops", n_stop - p0, 1);
        check("rd_sda_viol", n_viol - v0, 0);

        // address NACK
        s0 = n_start; p0 = n_stop; v0 = n_viol;
        run_txn(1'b0, 7'h21, 8'h5A, 1'b0, cyc, got, busy1);
        check("nk_done_seen", got, 1);
        check("nk_latency", cyc, 44 * DIV);
        check("nk_nack", bus.nack_err, 1);
        check("nk_addr_byte", mon_addr, 8'h42);
        check("nk_ack1", mon_ack1, 1);
        check("nk_scl_pulses", nbit, 10);
        check("nk_stops", n_stop - p0, 1);
        check("nk_starts", n_start - s0, 1);
        check("nk_sda_viol", n_viol - v0, 0);
        repeat (5) @(posedge clock);
        #1 check("nk_nack_held", bus.nack_err, 1);

        // write with a stray request mid-transfer
        s0 = n_start; p0 = n_stop; v0 = n_viol;
        run_txn(1'b0, 7'h20, 8'h69, 1'b1, cyc, got, busy1);
        check("pk_done_seen", got, 1);
        check("pk_latency", cyc, 80 * DIV);
        check("pk_nack_clr", bus.nack_err, 0);
        check("pk_addr_byte", mon_addr, 8'h40);
        check("pk_data_byte", mon_data, 8'h69);
        check("pk_starts", n_start - s0, 1);
        check("pk_stops", n_stop - p0, 1);
        check("pk_sda_viol", n_viol - v0, 0);
        repeat (3) @(posedge clock);
        #1 check("pk_idle_after", bus.busy, 0);

        // reset during WDATA bit 3
        @(negedge clock);
        bus.start_req = 1'b1;
        bus.rw        = 1'b0;
        bus.addr      = 7'h20;
        bus.wr_data   = 8'hFF;
        @(posedge clock);
        #1 bus.start_req = 1'b0;
        repeat (13 * 4 * DIV + 2) @(posedge clock);
        #1 check("mr_busy_before", bus.busy, 1);
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("mr_scl", bus.SCL_out, 1);
        check("mr_sda", bus.SDA_out, 1);
        check("mr_busy", bus.busy, 0);
        check("mr_rd_clr", bus.rd_data, 8'h00);
        @(posedge clock);
        #1;
        check("mr_scl_clk", bus.SCL_out, 1);
        check("mr_done", bus.done, 0);

        // request coincident with reset release
        @(negedge clock);
        reset         = 1'b0;
        bus.start_req = 1'b1;
        bus.rw        = 1'b0;
        bus.addr      = 7'h20;
        @(posedge clock);
        #1 bus.start_req = 1'b0;
        repeat (2) @(posedge clock);
        #1 check("rr_ignored", bus.busy, 0);

        // normal write after reset
        s0 = n_start; p0 = n_stop; v0 = n_viol;
        run_txn(1'b0, 7'h20, 8'hC3, 1'b0, cyc, got, busy1);
        check("aw_done_seen", got, 1);
        check("aw_latency", cyc, 80 * DIV);
        check("aw_data_byte", mon_data, 8'hC3);
        check("aw_nack", bus.nack_err, 0);
        check("aw_starts", n_start - s0, 1);
        check("aw_stops", n_stop - p0, 1);
        check("aw_sda_viol", n_viol - v0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
